// File: rtl/conv_output_buffer.sv
// conv_output_buffer
// Output-side stage behind the convolution MAC datapath. Each finished
// accumulator result is requantised to a narrower signed word with
// round-half-up and saturation. It is then registered in a stage and queued
// in a first-word-fall-through FIFO for the host.
// The upstream side cannot stall, so a push into a full FIFO is dropped and
// flagged in a sticky overflow bit.
// Ports:
//   clk, arst_n_in            clock, asynchronous active-low reset
//   in_valid/in_data/in_x/y/ch  one-cycle result pulse with coordinates
//   out_valid/out_ready       host handshake on the FIFO head
//   out_data/out_x/y/ch       requantised head entry (registered)
//   count                     FIFO occupancy
//   overflow, sat_count       sticky drop flag, saturated-result counter
//   clear_status              synchronous clear of overflow and sat_count
module conv_output_buffer #(
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SHIFT       = 8,
    parameter int unsigned COORD_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          in_valid,
    input  logic signed [ACC_WIDTH-1:0]   in_data,
    input  logic [COORD_WIDTH-1:0]        in_x,
    input  logic [COORD_WIDTH-1:0]        in_y,
    input  logic [COORD_WIDTH-1:0]        in_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic [COORD_WIDTH-1:0]        out_x,
    output logic [COORD_WIDTH-1:0]        out_y,
    output logic [COORD_WIDTH-1:0]        out_ch,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic [15:0]                   sat_count,
    input  logic                          clear_status
);

    localparam int unsigned AW1 = ACC_WIDTH + 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned SCW = 16;

    // Rounding constant 2^(SHIFT-1), or zero when SHIFT is zero.
    localparam logic signed [AW1-1:0] RND  = (AW1'(1) << SHIFT) >> 1;
    localparam logic signed [AW1-1:0] MAXV = (AW1'(1) << (OUT_WIDTH - 1)) - AW1'(1);
    localparam logic signed [AW1-1:0] MINV = ~MAXV;

    // Requantisation: one extra bit keeps the rounding add from wrapping.
    logic signed [AW1-1:0]       ext_c, rnd_c, r_c;
    logic signed [OUT_WIDTH-1:0] q_c;
    logic                        sat_c;

    always_comb begin
        ext_c = {in_data[ACC_WIDTH-1], in_data};
        rnd_c = ext_c + RND;
        r_c   = rnd_c >>> SHIFT;
        q_c   = OUT_WIDTH'(r_c);
        sat_c = 1'b0;
        if (r_c > MAXV) begin
            q_c   = OUT_WIDTH'(MAXV);
            sat_c = 1'b1;
        end else if (r_c < MINV) begin
            q_c   = OUT_WIDTH'(MINV);
            sat_c = 1'b1;
        end
    end

    // Stage register S1.
    logic                        s1_valid;
    logic                        s1_sat;
    logic signed [OUT_WIDTH-1:0] s1_data;
    logic [COORD_WIDTH-1:0]      s1_x, s1_y, s1_ch;

    // FIFO storage; contents need no reset since count qualifies them.
    logic signed [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [COORD_WIDTH-1:0]      mem_x    [FIFO_DEPTH];
    logic [COORD_WIDTH-1:0]      mem_y    [FIFO_DEPTH];
    logic [COORD_WIDTH-1:0]      mem_ch   [FIFO_DEPTH];
    logic [PW-1:0]               wptr, rptr;

    // Next-state signals.
    logic                        pop_c, full_c, push_c, drop_c, head_new_c;
    logic [PW-1:0]               wptr_n, rptr_n;
    logic [CW-1:0]               count_n;
    logic                        overflow_n;
    logic [SCW-1:0]              sat_count_n;

    always_comb begin
        pop_c   = out_valid && out_ready;
        full_c  = (count == CW'(FIFO_DEPTH));
        push_c  = s1_valid && (!full_c || pop_c);
        drop_c  = s1_valid && full_c && !pop_c;
        wptr_n  = wptr + PW'(push_c);
        rptr_n  = rptr + PW'(pop_c);
        count_n = count;
        unique case ({push_c, pop_c})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
        // The incoming entry becomes the head when it lands where the read
        // pointer points next (FIFO empty after this cycle's pop).
        head_new_c  = push_c && (wptr == rptr_n);
        overflow_n  = overflow;
        sat_count_n = sat_count;
        if (clear_status) begin
            overflow_n  = 1'b0;
            sat_count_n = '0;
        end else begin
            if (drop_c) begin
                overflow_n = 1'b1;
            end
            if (push_c && s1_sat && (sat_count != '1)) begin
                sat_count_n = sat_count + SCW'(1);
            end
        end
    end

    // FIFO write port.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data[wptr] <= s1_data;
            mem_x[wptr]    <= s1_x;
            mem_y[wptr]    <= s1_y;
            mem_ch[wptr]   <= s1_ch;
        end
    end

    // Stage, pointers, registered head and status.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            s1_valid  <= 1'b0;
            s1_sat    <= 1'b0;
            s1_data   <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_ch     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_ch    <= '0;
            overflow  <= 1'b0;
            sat_count <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_sat    <= sat_c;
            s1_data   <= q_c;
            s1_x      <= in_x;
            s1_y      <= in_y;
            s1_ch     <= in_ch;
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            count     <= count_n;
            out_valid <= (count_n != '0);
            if (head_new_c) begin
                out_data <= s1_data;
                out_x    <= s1_x;
                out_y    <= s1_y;
                out_ch   <= s1_ch;
            end else begin
                out_data <= mem_data[rptr_n];
                out_x    <= mem_x[rptr_n];
                out_y    <= mem_y[rptr_n];
                out_ch   <= mem_ch[rptr_n];
            end
            overflow  <= overflow_n;
            sat_count <= sat_count_n;
        end
    end

endmodule

// File: tb/tb_conv_output_buffer.sv
// Self-checking bench for conv_output_buffer: a reference model of
// queue semantics plus requantisation by integer arithmetic, with a monitor
// comparing every cycle.
module tb_conv_output_buffer;

    localparam int DEPTH = 8;
    localparam int SHIFT = 8;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        in_valid;
    logic [31:0] in_data, in_x, in_y, in_ch;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [31:0] out_x, out_y, out_ch;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] sat_count;
    logic        clear_status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_output_buffer #(
        .ACC_WIDTH(32), .OUT_WIDTH(16), .SHIFT(SHIFT), .COORD_WIDTH(32), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
        .count(count), .overflow(overflow), .sat_count(sat_count),
        .clear_status(clear_status)
    );

    typedef struct {
        logic [15:0] d;
        logic [31:0] x, y, ch;
        bit          sat;
    } ent_t;

    ent_t q[$];
    ent_t s1;
    bit   s1v;
    bit   m_ovf;
    int   m_sat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Requantise by floor division of the rounded value, then clamp.
    function automatic ent_t ref_model(input logic [31:0] d, input logic [31:0] x,
                                       input logic [31:0] y, input logic [31:0] ch);
        ent_t   e;
        longint v, den, num, qv;
        v   = longint'($signed(d));
        den = longint'(1) << SHIFT;
        num = v + den / 2;
        qv  = num / den;
        if ((num % den) != 0 && num < 0) qv = qv - 1;
        e.sat = 1'b0;
        if (qv > 32767) begin
            qv = 32767; e.sat = 1'b1;
        end else if (qv < -32768) begin
            qv = -32768; e.sat = 1'b1;
        end
        e.d  = 16'(qv);
        e.x  = x;
        e.y  = y;
        e.ch = ch;
        return e;
    endfunction

    // Monitor: advance the model by one clock edge and compare.
    always @(posedge clk) begin
        bit pop, full;
        #1;
        if (!arst_n_in) begin
            q.delete();
            s1v   = 1'b0;
            m_ovf = 1'b0;
            m_sat = 0;
        end else begin
            pop  = (q.size() != 0) && out_ready;
            full = (q.size() == DEPTH);
            if (pop) void'(q.pop_front());
            if (s1v) begin
                if (!full || pop) begin
                    q.push_back(s1);
                    if (s1.sat && m_sat < 65535) m_sat++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (clear_status) begin
                m_ovf = 1'b0;
                m_sat = 0;
            end
            s1v = in_valid;
            s1  = ref_model(in_data, in_x, in_y, in_ch);
        end
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("count", 64'(count), 64'(q.size()));
        if (q.size() != 0) begin
            check("head_data", 64'(out_data), 64'(q[0].d));
            check("head_xyz", {out_x, out_y ^ out_ch}, {q[0].x, q[0].y ^ q[0].ch});
            check("head_ch", 64'(out_ch), 64'(q[0].ch));
        end else if (!arst_n_in) begin
            check("reset_out_data", 64'(out_data), 64'(0));
            check("reset_out_xyz", 64'(out_x | out_y | out_ch), 64'(0));
        end
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("sat_count", 64'(sat_count), 64'(m_sat));
    end

    task automatic drive(input bit v, input logic [31:0] d, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ch,
                         input bit rdy, input bit clr);
        @(negedge clk);
        in_valid     = v;
        in_data      = d;
        in_x         = x;
        in_y         = y;
        in_ch        = ch;
        out_ready    = rdy;
        clear_status = clr;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        logic [31:0] r, d;
        int          p_rdy;
        arst_n_in = 1'b0; in_valid = 1'b0; in_data = '0; in_x = '0; in_y = '0; in_ch = '0;
        out_ready = 1'b0; clear_status = 1'b0;
        repeat (3) @(negedge clk);
        arst_n_in = 1'b1;

        // Single result: rounded 18.5 -> 19, visible two cycles later.
        drive(1'b1, 32'h0000_1280, 32'd10, 32'd20, 32'd30, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #2;
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_data", 64'(out_data), 64'h0013);
        check("single_x", 64'(out_x), 64'd10);
        idle(1'b1, 3);
        check("single_drained", 64'(count), 64'(0));

        // Saturation both ways and rounding of -1.5.
        drive(1'b1, 32'h7FFF_FFFF, 32'd1, 32'd1, 32'd1, 1'b1, 1'b0);
        drive(1'b1, 32'h8000_0000, 32'd2, 32'd2, 32'd2, 1'b1, 1'b0);
        drive(1'b1, 32'hFFFF_FE80, 32'd3, 32'd3, 32'd3, 1'b1, 1'b0);
        idle(1'b1, 4);
        check("sat_count_2", 64'(sat_count), 64'(2));

        // Back-pressure: nine pulses into an eight-deep FIFO.
        for (int i = 0; i < 9; i++)
            drive(1'b1, 32'(i * 512), 32'(i), 32'(i + 100), 32'(i + 200), 1'b0, 1'b0);
        idle(1'b0, 2);
        check("bp_count_full", 64'(count), 64'(8));
        check("bp_overflow", 64'(overflow), 64'(1));

        // Clear status without touching the queue.
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(1'b0, 1);
        check("clear_overflow", 64'(overflow), 64'(0));
        check("clear_sat", 64'(sat_count), 64'(0));
        check("clear_keeps_fifo", 64'(count), 64'(8));

        // Full FIFO with simultaneous push and pop.
        drive(1'b1, 32'h0000_0100, 32'd50, 32'd51, 32'd52, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'(i * 256 + 1024), 32'(60 + i), 32'(70 + i), 32'(80 + i), 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("fullpp_count", 64'(count), 64'(8));
        check("fullpp_no_overflow", 64'(overflow), 64'(0));
        idle(1'b1, 12);

        // Random traffic with varying host readiness.
        for (int i = 0; i < 10000; i++) begin
            p_rdy = (i / 1000) % 3 == 0 ? 30 : ((i / 1000) % 3 == 1 ? 60 : 95);
            r = $urandom;
            case ($urandom_range(0, 3))
                0: d = r;
                1: d = {{8{r[23]}}, r[23:0]};
                2: d = r[0] ? 32'h7FFF_FFFF : 32'h8000_0000;
                default: d = {{16{r[15]}}, r[15:0]};
            endcase
            drive(($urandom_range(0, 2) != 0), d, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 99) < p_rdy), ($urandom_range(0, 499) == 0));
        end
        idle(1'b1, 12);

        // Reset with five entries queued and S1 valid.
        for (int i = 0; i < 6; i++)
            drive(1'b1, 32'(i * 300), 32'(i), 32'(i), 32'(i), 1'b0, 1'b0);
        @(posedge clk); #2;
        check("pre_reset_count", 64'(count), 64'(5));
        arst_n_in = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_count", 64'(count), 64'(0));
        check("arst_data", 64'(out_data), 64'(0));
        check("arst_xyz", 64'(out_x | out_y | out_ch), 64'(0));
        check("arst_status", 64'({overflow, sat_count}), 64'(0));
        repeat (2) @(negedge clk);
        arst_n_in = 1'b1;
        drive(1'b1, 32'h0000_0280, 32'd7, 32'd8, 32'd9, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("post_reset_count", 64'(count), 64'(1));
        check("post_reset_data", 64'(out_data), 64'h0003);
        idle(1'b1, 4);
        check("post_reset_drained", 64'(count), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout reached t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_output_buffer.md
# conv_output_buffer

Output-side stage directly downstream of the convolution controller/MAC datapath. Captures each finished output pixel (accumulator value plus x/y/channel coordinates) on a single-cycle valid pulse and requantises it to a narrower signed word with rounding and saturation. Results are queued in a first-word-fall-through FIFO and presented to the host over a valid/ready handshake. The upstream side has no stall, so FIFO overflow is detected and reported rather than back-pressured.

## Interface
Parameters:
- ACC_WIDTH, 32, signed accumulator width of incoming results
- OUT_WIDTH, 16, signed width of requantised output (OUT_WIDTH ≤ ACC_WIDTH)
- SHIFT, 8, arithmetic right-shift amount, 0..ACC_WIDTH-1
- COORD_WIDTH, 32, width of x/y/ch coordinates
- FIFO_DEPTH, 8, entries; power of two, ≥ 2

Ports:
- clk  in  1  clock
- arst_n_in  in  1  reset; asynchronous, active-low
- in_valid  in  1  one-cycle pulse, result available
- in_data  in  ACC_WIDTH  signed accumulator result
- in_x, in_y, in_ch  in  COORD_WIDTH  coordinates of the result
- out_valid  out  1  FIFO head valid
- out_ready  in  1  host accepts head
- out_data  out  OUT_WIDTH  requantised head value
- out_x, out_y, out_ch  out  COORD_WIDTH  head coordinates
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; a result was dropped
- sat_count  out  16  number of saturated results, saturating at 0xFFFF
- clear_status  in  1  synchronous clear of overflow and sat_count

## Operation
- Requantise is computed combinationally from in_data:
  - If SHIFT>0: r = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_WIDTH+1 bits so the rounding add cannot wrap.
  - If SHIFT=0: r = in_data.
- Saturation:
  - r > 2^(OUT_WIDTH-1)-1 → 0x7FFF (for OUT_WIDTH=16).
  - r < -2^(OUT_WIDTH-1) → 0x8000.
  - Either case sets the per-result sat flag.
- Stage register S1 holds {valid, value, sat, x, y, ch}. S1 loads every cycle; its valid bit equals in_valid.
- FIFO push occurs when S1.valid is set. The push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle.
- Dropped push (S1.valid with FIFO full and no pop):
  - Entry is discarded and overflow is set.
  - FIFO contents are unchanged.
  - The sat flag of the dropped entry is not counted.
- sat_count increments by 1 per accepted push with sat=1, holding at 0xFFFF.
- Pop occurs when out_valid && out_ready.
- out_valid = (count ≠ 0). out_* always show the head entry; values are don't-care when empty.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Count update per cycle: +1 push-only, -1 pop-only, unchanged for simultaneous push and pop.
- clear_status in the same cycle as a new overflow or saturation event: clear wins and the event is lost.
- clear_status does not affect FIFO contents.

## Timing
- Reset (async, asserts immediately):
  - S1.valid=0, pointers=0, count=0.
  - out_valid=0, overflow=0, sat_count=0.
  - out_data, out_x, out_y, out_ch = 0.
- Latency: in_valid sampled at edge N is written to the FIFO at edge N+1. out_valid rises after edge N+1 if the FIFO was empty, i.e. two cycles from the input cycle to the first visible output.
- Back-to-back in_valid every cycle is sustained at full throughput while out_ready=1.
- Handshake: out_data and out_valid are stable while out_valid=1 and out_ready=0. out_ready may be asserted while out_valid=0; no effect.
- Full with simultaneous push and pop: the push is accepted, count stays FIFO_DEPTH, and no overflow is raised.
- Reset mid-operation: all queued entries and the in-flight S1 entry are lost; no partial output.
- No combinational path from in_* to out_*. out_ready affects only next-state logic.

## Test plan
- Single result, in_data=0x00001280, SHIFT=8, out_ready=1:
  - out_valid rises two cycles after in_valid.
  - out_data=0x0013 (rounded 18.5→19), coordinates match.
  - count returns to 0 after the pop.
- Saturation:
  - in_data=0x7FFFFFFF → out_data=0x7FFF.
  - in_data=0x80000000 → out_data=0x8000.
  - in_data=-384 → out_data=0xFFFF (rounding of -1.5).
  - sat_count=2 afterwards.
- Back-pressure, out_ready=0, 9 consecutive in_valid pulses, FIFO_DEPTH=8:
  - count reaches 8; overflow=1 after the 9th.
  - Draining yields the first 8 entries in order with coordinates intact.
- Full FIFO with push and pop in the same cycle: count stays 8, overflow stays 0, ordering is preserved.
- Random in_valid and out_ready for 10k cycles against a scoreboard: no loss or reorder while count never exceeds the depth. Pointer wrap is exercised many times.
- arst_n_in asserted with 5 entries queued and S1 valid:
  - All outputs go to reset values immediately.
  - After release, a new result appears alone.
  - clear_status zeroes overflow and sat_count.
